// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU request scheduler: opcode encodings,
// datapath widths and the scheduler state encoding.
package alu_sched_pkg;

    localparam int ALU_OP_W = 3;
    localparam int DATA_W   = 32;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Everything above SLT (101..111) has no ALU meaning.
    function automatic logic is_legal_op(input logic [ALU_OP_W-1:0] op);
        return (op <= ALU_SLT);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_any
);

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        // Walk the requests starting at ptr; the first hit wins.
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!grant_any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = IDW'(idx);
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one external combinational ALU among NREQ requesters: round-robin
// grant, operand latch, one execute cycle, then a held valid/ready response.
module alu_req_scheduler
    import alu_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [ALU_OP_W*NREQ-1:0] req_op,
    input  logic [DATA_W*NREQ-1:0]   req_a,
    input  logic [DATA_W*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]          req_ready,
    output logic [ALU_OP_W-1:0]      alu_ctr,
    output logic [DATA_W-1:0]        alu_a,
    output logic [DATA_W-1:0]        alu_b,
    input  logic [DATA_W-1:0]        alu_result,
    input  logic                     alu_zero,
    output logic                     rsp_valid,
    output logic [IDW-1:0]           rsp_id,
    output logic [DATA_W-1:0]        rsp_result,
    output logic                     rsp_zero,
    output logic                     rsp_err,
    input  logic                     rsp_ready
);

    logic [ALU_OP_W-1:0] op_arr [NREQ];
    logic [DATA_W-1:0]   a_arr  [NREQ];
    logic [DATA_W-1:0]   b_arr  [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign op_arr[gi] = req_op[ALU_OP_W*gi +: ALU_OP_W];
            assign a_arr[gi]  = req_a[DATA_W*gi +: DATA_W];
            assign b_arr[gi]  = req_b[DATA_W*gi +: DATA_W];
        end
    endgenerate

    state_t              state_reg;
    state_t              state_next;
    logic [IDW-1:0]      rr_ptr_reg;
    logic [IDW-1:0]      id_reg;
    logic [ALU_OP_W-1:0] op_reg;
    logic [DATA_W-1:0]   a_reg;
    logic [DATA_W-1:0]   b_reg;
    logic                err_reg;

    logic [NREQ-1:0]     grant;
    logic [IDW-1:0]      grant_idx;
    logic                grant_any;
    logic                accept;
    logic                grant_legal;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign accept      = (state_reg == ST_IDLE) && grant_any;
    assign grant_legal = is_legal_op(op_arr[grant_idx]);

    // The ALU sees only the latched operands, so its inputs are steady for the whole op.
    assign alu_ctr = op_reg;
    assign alu_a   = a_reg;
    assign alu_b   = b_reg;

    always_comb begin
        state_next = state_reg;
        req_ready  = '0;
        case (state_reg)
            ST_IDLE: begin
                // Gated by rst_n so a grant cannot leak out while reset is held.
                if (rst_n) begin
                    req_ready = grant;
                end
                if (grant_any) begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: state_next = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            rr_ptr_reg <= '0;
            id_reg     <= '0;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            err_reg    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                // Illegal opcodes run as a harmless ADD; the result is discarded later.
                op_reg     <= grant_legal ? op_arr[grant_idx] : ALU_ADD;
                err_reg    <= !grant_legal;
                a_reg      <= a_arr[grant_idx];
                b_reg      <= b_arr[grant_idx];
                id_reg     <= grant_idx;
                rr_ptr_reg <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
            end
            if (state_reg == ST_EXEC) begin
                rsp_valid  <= 1'b1;
                rsp_id     <= id_reg;
                rsp_err    <= err_reg;
                rsp_result <= err_reg ? '0 : alu_result;
                rsp_zero   <= !err_reg && alu_zero;
            end
            if ((state_reg == ST_RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
